hazard_stall_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32 core; complements EX-stage operand forwarding.

---
 rtl/hazard_stall_controller_if.sv | 42 ++++
 rtl/hazard_stall_controller.sv | 152 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Handshake bundle between the 5-stage pipeline datapath and the hazard/stall controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             useRs1Id;
    logic             useRs2Id;
    logic [4:0]       rd_ex;
    logic             memReadEx;
    logic             branchTakenEx;
    logic             divStartEx;
    logic             divDone;
    logic             memReqMem;
    logic             memAckMem;
    logic             stallPc;
    logic             stallIfId;
    logic             stallIdEx;
    logic             stallExMem;
    logic             flushIfId;
    logic             flushIdEx;
    logic             flushExMem;
    logic             flushMemWb;
    logic             divGo;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output rs1_id, rs2_id, useRs1Id, useRs2Id, rd_ex, memReadEx, branchTakenEx,
               divStartEx, divDone, memReqMem, memAckMem,
        input  stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, flushIdEx,
               flushExMem, flushMemWb, divGo, memTimeout, stallCycles
    );

    modport slave (
        input  rs1_id, rs2_id, useRs1Id, useRs2Id, rd_ex, memReadEx, branchTakenEx,
               divStartEx, divDone, memReqMem, memAckMem,
        output stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, flushIdEx,
               flushExMem, flushMemWb, divGo, memTimeout, stallCycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, multi-cycle memory
// wait with timeout, iterative divider sequencing and a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_stall_controller_if.slave hs
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic mem_wait_s, load_use_s, run_evt_s;
    logic stall_pc_s, stall_if_id_s, stall_id_ex_s, stall_ex_mem_s;
    logic flush_if_id_s, flush_id_ex_s, flush_ex_mem_s, flush_mem_wb_s;
    logic div_go_s, mem_timeout_s;

    // Next-state and stall/flush decode, highest-priority event first
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        run_evt_s      = 1'b0;
        stall_pc_s     = 1'b0;
        stall_if_id_s  = 1'b0;
        stall_id_ex_s  = 1'b0;
        stall_ex_mem_s = 1'b0;
        flush_if_id_s  = 1'b0;
        flush_id_ex_s  = 1'b0;
        flush_ex_mem_s = 1'b0;
        flush_mem_wb_s = 1'b0;
        div_go_s       = 1'b0;
        mem_timeout_s  = 1'b0;

        mem_wait_s = hs.memReqMem & ~hs.memAckMem;
        load_use_s = hs.memReadEx & (hs.rd_ex != 5'd0) &
                     ((hs.useRs1Id & (hs.rs1_id == hs.rd_ex)) |
                      (hs.useRs2Id & (hs.rs2_id == hs.rd_ex)));

        case (state_q)
            DIV_BUSY: begin
                if (hs.divDone) begin
                    state_d = RUN;
                end else begin
                    stall_pc_s     = 1'b1;
                    stall_if_id_s  = 1'b1;
                    stall_id_ex_s  = 1'b1;
                    flush_ex_mem_s = 1'b1;
                end
            end
            MEM_BUSY: begin
                if (!mem_wait_s) begin
                    // Access completed: the pipeline advances and sees this cycle's hazards
                    state_d    = RUN;
                    wait_cnt_d = {WCNT_W{1'b0}};
                    run_evt_s  = 1'b1;
                end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    mem_timeout_s = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = {WCNT_W{1'b0}};
                end else begin
                    stall_pc_s     = 1'b1;
                    stall_if_id_s  = 1'b1;
                    stall_id_ex_s  = 1'b1;
                    stall_ex_mem_s = 1'b1;
                    flush_mem_wb_s = 1'b1;
                    wait_cnt_d     = wait_cnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (mem_wait_s) begin
                    stall_pc_s     = 1'b1;
                    stall_if_id_s  = 1'b1;
                    stall_id_ex_s  = 1'b1;
                    stall_ex_mem_s = 1'b1;
                    flush_mem_wb_s = 1'b1;
                    state_d        = MEM_BUSY;
                    wait_cnt_d     = {{(WCNT_W-1){1'b0}}, 1'b1};
                end else begin
                    run_evt_s = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = {WCNT_W{1'b0}};
            end
        endcase

        if (run_evt_s) begin
            if (hs.branchTakenEx) begin
                flush_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
            end else if (hs.divStartEx) begin
                div_go_s       = 1'b1;
                stall_pc_s     = 1'b1;
                stall_if_id_s  = 1'b1;
                stall_id_ex_s  = 1'b1;
                flush_ex_mem_s = 1'b1;
                state_d        = DIV_BUSY;
            end else if (load_use_s) begin
                stall_pc_s    = 1'b1;
                stall_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
            end else begin
                state_d = state_d;
            end
        end else begin
            run_evt_s = 1'b0;
        end

        if (stall_pc_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // FSM state, wait counter and performance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= {WCNT_W{1'b0}};
            stall_cycles_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Controls are forced quiet while reset is held, independent of inputs
    assign hs.stallPc     = stall_pc_s     & rst_n;
    assign hs.stallIfId   = stall_if_id_s  & rst_n;
    assign hs.stallIdEx   = stall_id_ex_s  & rst_n;
    assign hs.stallExMem  = stall_ex_mem_s & rst_n;
    assign hs.flushIfId   = flush_if_id_s  & rst_n;
    assign hs.flushIdEx   = flush_id_ex_s  & rst_n;
    assign hs.flushExMem  = flush_ex_mem_s & rst_n;
    assign hs.flushMemWb  = flush_mem_wb_s & rst_n;
    assign hs.divGo       = div_go_s       & rst_n;
    assign hs.memTimeout  = mem_timeout_s  & rst_n;
    assign hs.stallCycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed table-driven bench for hazard_stall_controller plus multi-cycle sequences
// for the divider, memory wait, memory timeout and mid-wait reset.
module tb_hazard_stall_controller;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] c0;

    hazard_stall_controller_if #(.CNT_W(32)) hsif ();

    hazard_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hs    (hsif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-pattern bit order:
    // {stallPc,stallIfId,stallIdEx,stallExMem,flushIfId,flushIdEx,flushExMem,flushMemWb,divGo,memTimeout}
    localparam logic [9:0] P_NONE = 10'b0000_0000_00;
    localparam logic [9:0] P_LU   = 10'b1100_0100_00;
    localparam logic [9:0] P_BR   = 10'b0000_1100_00;
    localparam logic [9:0] P_MEM  = 10'b1111_0001_00;
    localparam logic [9:0] P_DGO  = 10'b1110_0010_10;
    localparam logic [9:0] P_DIV  = 10'b1110_0010_00;
    localparam logic [9:0] P_TO   = 10'b0000_0000_01;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       mreq;
        logic       mack;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [9:0] outs();
        return {hsif.stallPc, hsif.stallIfId, hsif.stallIdEx, hsif.stallExMem,
                hsif.flushIfId, hsif.flushIdEx, hsif.flushExMem, hsif.flushMemWb,
                hsif.divGo, hsif.memTimeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clr();
        hsif.rs1_id = 5'd0; hsif.rs2_id = 5'd0; hsif.useRs1Id = 1'b0; hsif.useRs2Id = 1'b0;
        hsif.rd_ex = 5'd0; hsif.memReadEx = 1'b0; hsif.branchTakenEx = 1'b0;
        hsif.divStartEx = 1'b0; hsif.divDone = 1'b0; hsif.memReqMem = 1'b0; hsif.memAckMem = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard();
        hsif.memReadEx = 1'b1; hsif.rd_ex = 5'd5; hsif.rs1_id = 5'd5; hsif.useRs1Id = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{"lu_rs1",     5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};
        vecs[1] = '{"rd_zero",    5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_NONE};
        vecs[2] = '{"no_use1",    5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_NONE};
        vecs[3] = '{"lu_rs2",     5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};
        vecs[4] = '{"not_load",   5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE};
        vecs[5] = '{"branch_lu",  5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, P_BR};
        vecs[6] = '{"mem_ack0",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_NONE};
        vecs[7] = '{"rs_mismatch",5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_NONE};
        vecs[8] = '{"idle",       5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE};

        clr();
        rst_n = 1'b0;
        hazard();
        #3;
        chk("reset_outs", 32'(outs()), 32'(P_NONE));
        chk("reset_cnt", hsif.stallCycles, 32'd0);
        clr();
        cyc(); cyc();
        rst_n = 1'b1;

        // Single-cycle combinational vectors from RUN
        foreach (vecs[i]) begin
            cyc();
            hsif.rs1_id = vecs[i].rs1; hsif.rs2_id = vecs[i].rs2;
            hsif.useRs1Id = vecs[i].u1; hsif.useRs2Id = vecs[i].u2;
            hsif.rd_ex = vecs[i].rd; hsif.memReadEx = vecs[i].mr;
            hsif.branchTakenEx = vecs[i].br; hsif.memReqMem = vecs[i].mreq;
            hsif.memAckMem = vecs[i].mack;
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end
        cyc(); clr(); #1;
        chk("after_lu_none", 32'(outs()), 32'(P_NONE));
        chk("cnt_after_vecs", hsif.stallCycles, 32'd2);

        // Divider: start at t0, done at t0+33
        cyc(); clr();
        c0 = hsif.stallCycles;
        hsif.divStartEx = 1'b1; #1;
        chk("div_start", 32'(outs()), 32'(P_DGO));
        for (int k = 1; k <= 32; k++) begin
            cyc(); clr(); #1;
            chk($sformatf("div_busy_%0d", k), 32'(outs()), 32'(P_DIV));
        end
        cyc(); hsif.divDone = 1'b1; #1;
        chk("div_done", 32'(outs()), 32'(P_NONE));
        chk("div_cnt", hsif.stallCycles - c0, 32'd33);
        cyc(); clr(); hsif.divDone = 1'b1; #1;
        chk("div_done_ignored", 32'(outs()), 32'(P_NONE));
        cyc(); clr(); hazard(); #1;
        chk("lu_after_div", 32'(outs()), 32'(P_LU));

        // Memory access acked on the 4th cycle
        cyc(); clr();
        c0 = hsif.stallCycles;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin cyc(); end
            hsif.memReqMem = 1'b1; #1;
            chk($sformatf("mem_wait_%0d", k), 32'(outs()), 32'(P_MEM));
        end
        cyc(); hsif.memAckMem = 1'b1; #1;
        chk("mem_ack", 32'(outs()), 32'(P_NONE));
        chk("mem_cnt", hsif.stallCycles - c0, 32'd3);

        // Memory access never acked: abort on the 16th cycle
        cyc(); clr(); hsif.memReqMem = 1'b1; #1;
        chk("to_wait_1", 32'(outs()), 32'(P_MEM));
        for (int k = 2; k <= 15; k++) begin
            cyc(); #1;
            if (k == 15) chk("to_wait_15", 32'(outs()), 32'(P_MEM));
        end
        cyc(); #1;
        chk("to_pulse", 32'(outs()), 32'(P_TO));
        cyc(); clr(); hazard(); #1;
        chk("to_back_run", 32'(outs()), 32'(P_LU));

        // Reset asserted while the divider is busy
        cyc(); clr(); hsif.divStartEx = 1'b1;
        cyc(); clr();
        cyc(); #1;
        chk("rst_div_pre", 32'(outs()), 32'(P_DIV));
        rst_n = 1'b0; #1;
        chk("rst_div_async", 32'(outs()), 32'(P_NONE));
        chk("rst_div_cnt", hsif.stallCycles, 32'd0);
        cyc(); rst_n = 1'b1;
        cyc(); hsif.divDone = 1'b1; #1;
        chk("rst_div_done_ign", 32'(outs()), 32'(P_NONE));
        cyc(); clr(); #1;
        chk("rst_div_run", 32'(outs()), 32'(P_NONE));

        // Reset asserted while waiting on memory
        cyc(); hsif.memReqMem = 1'b1;
        cyc(); cyc(); #1;
        chk("rst_mem_pre", 32'(outs()), 32'(P_MEM));
        rst_n = 1'b0; #1;
        chk("rst_mem_async", 32'(outs()), 32'(P_NONE));
        cyc(); clr(); rst_n = 1'b1;
        cyc(); #1;
        chk("rst_mem_run", 32'(outs()), 32'(P_NONE));
        chk("rst_mem_cnt", hsif.stallCycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
